// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: programmable SPI serial-clock burst generator.
//
// On an accepted start, latches half-period, bit count and idle polarity, then
// produces exactly num_bits SCLK periods (2*half_period clk cycles each) and
// returns SCLK to its idle level. One-cycle strobes mark every edge away from
// the idle level (lead) and every edge back to it (trail) for the shift/sample
// logic.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               request a burst (accepted only while not busy)
//   stop                abort a running burst; blocks start while idle
//   half_period[CNT_W]  clk cycles per SCLK half-period (0 behaves as 1)
//   num_bits[LEN_W]     SCLK periods per burst (0 gives an immediate done)
//   cpol                SCLK idle level
//   sclk                registered serial clock
//   lead_strobe         pulse with each edge away from idle
//   trail_strobe        pulse with each edge back to idle
//   busy                burst in progress
//   done                pulse when a burst completes normally
module spi_sclk_gen #(
  parameter int CNT_W = 26,
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] half_period,
  input  logic [LEN_W-1:0] num_bits,
  input  logic             cpol,
  output logic             sclk,
  output logic             lead_strobe,
  output logic             trail_strobe,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W:0]   tog_q, tog_d;   // SCLK toggles issued so far, up to 2*nb
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [LEN_W-1:0] nb_q, nb_d;
  logic             pol_q, pol_d;
  logic             sclk_q, sclk_d;
  logic             lead_q, lead_d;
  logic             trail_q, trail_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W:0]   tog_inc;
  logic             new_sclk;

  assign tog_inc  = tog_q + 1'b1;
  assign new_sclk = ~sclk_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    hp_d    = hp_q;
    nb_d    = nb_q;
    pol_d   = pol_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Idle SCLK tracks the live cpol so the pad sits at the right level
        // before the first burst.
        sclk_d = cpol;
        if (start && !stop) begin
          hp_d  = (half_period == '0) ? CNT_W'(1) : half_period;
          nb_d  = num_bits;
          pol_d = cpol;
          cnt_d = '0;
          tog_d = '0;
          if (num_bits == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (stop) begin
          // Abort wins over a coincident terminal edge: no strobe, no done.
          state_d = IDLE;
          busy_d  = 1'b0;
          sclk_d  = pol_q;
          cnt_d   = '0;
        end else if (cnt_q == hp_q - CNT_W'(1)) begin
          cnt_d  = '0;
          tog_d  = tog_inc;
          sclk_d = new_sclk;
          if (new_sclk != pol_q) lead_d  = 1'b1;
          else                   trail_d = 1'b1;
          if (tog_inc == {nb_q, 1'b0}) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      hp_q    <= '0;
      nb_q    <= '0;
      pol_q   <= 1'b0;
      sclk_q  <= 1'b0;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      hp_q    <= hp_d;
      nb_q    <= nb_d;
      pol_q   <= pol_d;
      sclk_q  <= sclk_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sclk         = sclk_q;
  assign lead_strobe  = lead_q;
  assign trail_strobe = trail_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
